decode_scoreboard: RTL and testbench
====================================

Name: decode_scoreboard

Overview:
- Register-interlock controller for the decode stage of the DLX pipeline.
- Tracks in-flight register writes from issue to writeback with a per-register pending counter.
- Stalls the decoder while a source operand of the current instruction is still pending, or while the destination's counter is saturated.
- Sits between the instruction decoder outputs (register addresses, instruction class) and the issue/writeback pipeline control.

Parameters:
REG_ADDR_WIDTH, 5, register address width; scoreboard has 2**REG_ADDR_WIDTH entries
DECODED_INST_WIDTH, 4, width of the instruction-class code (R_INST/I_INST/J_INST from general_parameters.v)
PENDING_CNT_WIDTH, 2, per-register pending counter width; max in-flight writes per register = 2**PENDING_CNT_WIDTH-1

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
id_valid_in  input  1  decode stage holds a valid instruction
decoded_inst_in  input  DECODED_INST_WIDTH  instruction class
read_address1_in  input  REG_ADDR_WIDTH  source register 1
read_address2_in  input  REG_ADDR_WIDTH  source register 2
write_address_in  input  REG_ADDR_WIDTH  destination register
writes_reg_in  input  1  instruction writes write_address_in
id_ready_out  output  1  instruction may issue this cycle
issue_out  output  1  one-cycle pulse, instruction accepted
stall_out  output  1  id_valid_in and not id_ready_out
wb_valid_in  input  1  writeback retires a register write
wb_address_in  input  REG_ADDR_WIDTH  retired destination
flush_in  input  1  pipeline flush, clears all pending state
busy_out  output  1  any counter non-zero
protocol_error_out  output  1  sticky, writeback to a register with counter 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all counters 0, protocol_error_out 0, busy_out 0.
  - While rst is high, id_ready_out=0, issue_out=0, stall_out follows id_valid_in.
- Source usage by class:
  - R_INST uses rs1 and rs2.
  - I_INST uses rs1 only.
  - J_INST and any other code use neither.
- Register 0: never pending. Issue and writeback targeting address 0 are ignored, and sources equal to 0 never hazard.
- raw_hazard: a used source with its registered counter != 0.
- sat_hazard: writes_reg_in && dest!=0 && cnt[dest]==max.
- id_ready_out (combinational) = !rst && !flush_in && !raw_hazard && !sat_hazard.
- issue_out = id_valid_in && id_ready_out. Zero latency, same cycle.
- Counter update at the clock edge:
  - Increment cnt[dest] on issue with writes_reg_in.
  - Decrement cnt[wb_address_in] on wb_valid_in when it is non-zero.
  - Same register incremented and decremented in the same cycle: unchanged.
  - Different registers: both updates apply.
- Writeback release is not bypassed. A source freed by wb_valid_in in cycle N is first seen as free in cycle N+1, so a dependent instruction stalls exactly one extra cycle.
- wb_valid_in on a counter at 0 (non-zero address):
  - Counter stays 0.
  - protocol_error_out is set and stays set until rst.
- flush_in:
  - Highest priority after rst.
  - All counters cleared at the next edge.
  - Concurrent issue and writeback are discarded.
  - id_ready_out=0 in the flush cycle.
  - protocol_error_out is not set by a concurrent writeback.
- Reset mid-operation: all state cleared at the next edge. In-flight writebacks arriving later raise protocol_error_out.
- busy_out is registered and reflects the counters after the edge.

Optional Feature:
SCOREBOARD_WB_BYPASS_EN
- Defined: the hazard check uses cnt minus one for the register on wb_address_in when wb_valid_in is high.
  - A dependent instruction issues in the same cycle as the release.
  - Saturation check uses the same adjusted value.
- Undefined: registered counters only, with the one-cycle release penalty above.

Test Plan:
- Reset then R_INST rs1=3 rs2=4 rd=5 valid -> issue_out=1 same cycle; cnt[5]=1, busy_out=1 next cycle.
- Issue rd=5, next R_INST rs1=5 -> stall_out=1; wb_valid_in rd=5 in cycle N -> issue in N+1, or in N with SCOREBOARD_WB_BYPASS_EN.
- J_INST with read_address1_in=5 while cnt[5]=1 -> issues; I_INST rs1=0 or rd=0 -> issues, with no counter change for rd=0.
- Three issues to rd=7 -> cnt=3; fourth stalls; wb rd=7 -> fourth issues the cycle after, cnt back to 3.
- Issue rd=9 and wb rd=9 in the same cycle with cnt[9]=1 -> cnt stays 1; wb rd=12 with cnt[12]=0 -> protocol_error_out=1 until rst.
- cnt[5]=2, cnt[6]=1, flush_in with concurrent valid issue -> no issue_out; next cycle all counters 0, busy_out=0.

Source files
------------

// File: rtl/decode_scoreboard.sv
// Decode-stage register interlock: per-register pending-write counters gate instruction issue.
// Optional SCOREBOARD_WB_BYPASS_EN lets a same-cycle writeback release count toward the hazard check.
module decode_scoreboard #(
    parameter int REG_ADDR_WIDTH     = 5,
    parameter int DECODED_INST_WIDTH = 4,
    parameter int PENDING_CNT_WIDTH  = 2,
    parameter logic [DECODED_INST_WIDTH-1:0] R_INST = DECODED_INST_WIDTH'(1),
    parameter logic [DECODED_INST_WIDTH-1:0] I_INST = DECODED_INST_WIDTH'(2),
    parameter logic [DECODED_INST_WIDTH-1:0] J_INST = DECODED_INST_WIDTH'(3)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_valid_in,
    input  logic [DECODED_INST_WIDTH-1:0] decoded_inst_in,
    input  logic [REG_ADDR_WIDTH-1:0]     read_address1_in,
    input  logic [REG_ADDR_WIDTH-1:0]     read_address2_in,
    input  logic [REG_ADDR_WIDTH-1:0]     write_address_in,
    input  logic                          writes_reg_in,
    output logic                          id_ready_out,
    output logic                          issue_out,
    output logic                          stall_out,
    input  logic                          wb_valid_in,
    input  logic [REG_ADDR_WIDTH-1:0]     wb_address_in,
    input  logic                          flush_in,
    output logic                          busy_out,
    output logic                          protocol_error_out
);

    localparam int unsigned NUM_REGS = 2 ** REG_ADDR_WIDTH;
    localparam logic [PENDING_CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [PENDING_CNT_WIDTH-1:0] cnt      [NUM_REGS];
    logic [PENDING_CNT_WIDTH-1:0] cnt_next [NUM_REGS];
    logic [PENDING_CNT_WIDTH-1:0] cnt_rs1, cnt_rs2, cnt_wd;
    logic use_rs1, use_rs2, raw_hazard, sat_hazard;
    logic wb_live, wb_orphan, inc_en;
    logic busy, busy_next, protocol_error, perr_next;

    // J_INST and unknown class codes read no sources.
    always_comb begin
        use_rs2 = (decoded_inst_in == R_INST);
        use_rs1 = use_rs2 || (decoded_inst_in == I_INST);
        wb_live = wb_valid_in && (wb_address_in != '0) && (cnt[wb_address_in] != '0);
        cnt_rs1 = cnt[read_address1_in];
        cnt_rs2 = cnt[read_address2_in];
        cnt_wd  = cnt[write_address_in];
`ifdef SCOREBOARD_WB_BYPASS_EN
        if (wb_live) begin
            if (read_address1_in == wb_address_in) cnt_rs1 = cnt_rs1 - 1'b1;
            if (read_address2_in == wb_address_in) cnt_rs2 = cnt_rs2 - 1'b1;
            if (write_address_in == wb_address_in) cnt_wd  = cnt_wd  - 1'b1;
        end
`endif
        raw_hazard = (use_rs1 && (read_address1_in != '0) && (cnt_rs1 != '0)) ||
                     (use_rs2 && (read_address2_in != '0) && (cnt_rs2 != '0));
        sat_hazard = writes_reg_in && (write_address_in != '0) && (cnt_wd == CNT_MAX);
        id_ready_out = !rst && !flush_in && !raw_hazard && !sat_hazard;
        issue_out    = id_valid_in && id_ready_out;
        stall_out    = id_valid_in && !id_ready_out;
    end

    // Same-register increment and decrement cancel through the +1/-1 pair.
    always_comb begin
        cnt_next  = cnt;
        perr_next = protocol_error;
        inc_en    = issue_out && writes_reg_in && (write_address_in != '0);
        wb_orphan = wb_valid_in && (wb_address_in != '0) && (cnt[wb_address_in] == '0);
        if (flush_in) begin
            cnt_next = '{default: '0};
        end else begin
            if (inc_en)    cnt_next[write_address_in] = cnt_next[write_address_in] + 1'b1;
            if (wb_live)   cnt_next[wb_address_in]    = cnt_next[wb_address_in] - 1'b1;
            if (wb_orphan) perr_next = 1'b1;
        end
        busy_next = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            busy_next = busy_next | (cnt_next[i] != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                cnt[i] <= '0;
            end
            busy           <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            cnt            <= cnt_next;
            busy           <= busy_next;
            protocol_error <= perr_next;
        end
    end

    assign busy_out           = busy;
    assign protocol_error_out = protocol_error;

endmodule

// File: tb/tb_decode_scoreboard.sv
// Scoreboard bench for decode_scoreboard: directed test-plan sequences followed by random traffic,
// checked against a counter-array reference model (honours SCOREBOARD_WB_BYPASS_EN when defined).
module tb_decode_scoreboard;

    localparam logic [3:0] R_C = 4'd1;
    localparam logic [3:0] I_C = 4'd2;
    localparam logic [3:0] J_C = 4'd3;
    localparam int CNT_MAX = 3;

    typedef struct {
        logic       rst;
        logic       valid;
        logic [3:0] cls;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] wd;
        logic       wr;
        logic       wbv;
        logic [4:0] wba;
        logic       flush;
    } stim_t;

    typedef struct {
        logic ready;
        logic issue;
        logic stall;
        logic busy;
        logic perr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid_in;
    logic [3:0] decoded_inst_in;
    logic [4:0] read_address1_in;
    logic [4:0] read_address2_in;
    logic [4:0] write_address_in;
    logic       writes_reg_in;
    logic       id_ready_out;
    logic       issue_out;
    logic       stall_out;
    logic       wb_valid_in;
    logic [4:0] wb_address_in;
    logic       flush_in;
    logic       busy_out;
    logic       protocol_error_out;

    exp_t exp_q[$];
    int   m_cnt[32];
    bit   m_perr;
    int   tests = 0;
    int   fails = 0;
    int   cycle = 0;

    decode_scoreboard #(
        .REG_ADDR_WIDTH(5),
        .DECODED_INST_WIDTH(4),
        .PENDING_CNT_WIDTH(2),
        .R_INST(R_C),
        .I_INST(I_C),
        .J_INST(J_C)
    ) dut (
        .clk(clk),
        .rst(rst),
        .id_valid_in(id_valid_in),
        .decoded_inst_in(decoded_inst_in),
        .read_address1_in(read_address1_in),
        .read_address2_in(read_address2_in),
        .write_address_in(write_address_in),
        .writes_reg_in(writes_reg_in),
        .id_ready_out(id_ready_out),
        .issue_out(issue_out),
        .stall_out(stall_out),
        .wb_valid_in(wb_valid_in),
        .wb_address_in(wb_address_in),
        .flush_in(flush_in),
        .busy_out(busy_out),
        .protocol_error_out(protocol_error_out)
    );

    always #5 clk = ~clk;

    function automatic stim_t mk(input logic valid, input logic [3:0] cls,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [4:0] wd, input logic wr,
                                 input logic wbv, input logic [4:0] wba,
                                 input logic flush, input logic rst_v);
        stim_t s;
        s.rst = rst_v; s.valid = valid; s.cls = cls; s.rs1 = rs1; s.rs2 = rs2;
        s.wd = wd; s.wr = wr; s.wbv = wbv; s.wba = wba; s.flush = flush;
        return s;
    endfunction

    // Drive one cycle, queue the expected response, then advance the model across the edge.
    task automatic apply(input stim_t s);
        int   e1, e2, ew;
        bit   used1, used2, rdy, any;
        exp_t e;
        @(negedge clk);
        rst = s.rst; id_valid_in = s.valid; decoded_inst_in = s.cls;
        read_address1_in = s.rs1; read_address2_in = s.rs2;
        write_address_in = s.wd; writes_reg_in = s.wr;
        wb_valid_in = s.wbv; wb_address_in = s.wba; flush_in = s.flush;

        used1 = (s.cls == R_C) || (s.cls == I_C);
        used2 = (s.cls == R_C);
        e1 = m_cnt[s.rs1]; e2 = m_cnt[s.rs2]; ew = m_cnt[s.wd];
`ifdef SCOREBOARD_WB_BYPASS_EN
        if (s.wbv && s.wba != 0 && m_cnt[s.wba] > 0) begin
            if (s.rs1 == s.wba) e1 = e1 - 1;
            if (s.rs2 == s.wba) e2 = e2 - 1;
            if (s.wd == s.wba)  ew = ew - 1;
        end
`endif
        rdy = !s.rst && !s.flush
              && !(used1 && s.rs1 != 0 && e1 > 0)
              && !(used2 && s.rs2 != 0 && e2 > 0)
              && !(s.wr && s.wd != 0 && ew == CNT_MAX);
        any = 0;
        foreach (m_cnt[i]) if (m_cnt[i] > 0) any = 1;
        e.ready = rdy; e.issue = s.valid && rdy; e.stall = s.valid && !rdy;
        e.busy = any; e.perr = m_perr;
        exp_q.push_back(e);

        if (s.rst) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
            m_perr = 0;
        end else if (s.flush) begin
            foreach (m_cnt[i]) m_cnt[i] = 0;
        end else begin
            bit dec_ok;
            dec_ok = s.wbv && s.wba != 0 && m_cnt[s.wba] > 0;
            if (s.wbv && s.wba != 0 && m_cnt[s.wba] == 0) m_perr = 1;
            if (e.issue && s.wr && s.wd != 0) m_cnt[s.wd] = m_cnt[s.wd] + 1;
            if (dec_ok) m_cnt[s.wba] = m_cnt[s.wba] - 1;
        end
    endtask

    task automatic chk(input string name, input logic act, input logic req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cycle, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            cycle++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("id_ready", id_ready_out, e.ready);
                chk("issue", issue_out, e.issue);
                chk("stall", stall_out, e.stall);
                chk("busy", busy_out, e.busy);
                chk("protocol_error", protocol_error_out, e.perr);
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(mk(0, J_C, 0, 0, 0, 0, 0, 0, 0, 0));
    endtask

    initial begin : stimulus
        stim_t s;
        int    tries;
        foreach (m_cnt[i]) m_cnt[i] = 0;
        m_perr = 0;
        rst = 1; id_valid_in = 0; decoded_inst_in = '0; read_address1_in = '0;
        read_address2_in = '0; write_address_in = '0; writes_reg_in = 0;
        wb_valid_in = 0; wb_address_in = '0; flush_in = 0;
        repeat (2) @(posedge clk);

        // Checked reset cycles: stall follows valid, nothing issues.
        apply(mk(1, R_C, 3, 4, 5, 1, 0, 0, 0, 1));
        apply(mk(0, R_C, 3, 4, 5, 1, 0, 0, 0, 1));

        // Basic issue, RAW stall and writeback release.
        apply(mk(1, R_C, 3, 4, 5, 1, 0, 0, 0, 0));
        apply(mk(1, R_C, 5, 0, 8, 1, 0, 0, 0, 0));
        apply(mk(1, R_C, 5, 0, 8, 1, 1, 5, 0, 0));
        apply(mk(1, R_C, 5, 0, 8, 1, 0, 0, 0, 0));
        apply(mk(0, R_C, 0, 0, 0, 0, 1, 8, 0, 0));
        apply(mk(0, R_C, 0, 0, 0, 0, 1, 8, 0, 0));

        // Class-based source usage and register 0.
        apply(mk(1, R_C, 3, 4, 5, 1, 0, 0, 0, 0));
        apply(mk(1, J_C, 5, 5, 0, 0, 0, 0, 0, 0));
        apply(mk(1, I_C, 0, 5, 0, 1, 0, 0, 0, 0));
        apply(mk(1, I_C, 5, 0, 0, 1, 0, 0, 0, 0));
        apply(mk(1, 4'd9, 5, 5, 0, 0, 0, 0, 0, 0));
        apply(mk(0, R_C, 0, 0, 0, 0, 1, 5, 0, 0));

        // Saturation on rd=7.
        repeat (3) apply(mk(1, J_C, 0, 0, 7, 1, 0, 0, 0, 0));
        apply(mk(1, J_C, 0, 0, 7, 1, 0, 0, 0, 0));
        apply(mk(1, J_C, 0, 0, 7, 1, 1, 7, 0, 0));
        apply(mk(1, J_C, 0, 0, 7, 1, 0, 0, 0, 0));
        apply(mk(1, R_C, 7, 0, 0, 0, 0, 0, 0, 0));

        // Same-cycle issue and writeback to rd=9.
        apply(mk(1, J_C, 0, 0, 9, 1, 0, 0, 0, 0));
        apply(mk(1, J_C, 0, 0, 9, 1, 1, 9, 0, 0));
        apply(mk(1, I_C, 9, 0, 0, 0, 0, 0, 0, 0));

        // Flush with concurrent issue and writeback.
        apply(mk(1, J_C, 0, 0, 5, 1, 0, 0, 0, 0));
        apply(mk(1, J_C, 0, 0, 5, 1, 0, 0, 0, 0));
        apply(mk(1, J_C, 0, 0, 6, 1, 0, 0, 0, 0));
        apply(mk(1, J_C, 0, 0, 10, 1, 1, 5, 1, 0));
        idle(2);

        // Orphan writeback makes the error sticky until reset.
        apply(mk(0, J_C, 0, 0, 0, 0, 1, 12, 0, 0));
        idle(3);
        apply(mk(0, J_C, 0, 0, 0, 0, 0, 0, 0, 1));
        idle(2);

        for (int n = 0; n < 3000; n++) begin
            s.rst   = ($urandom_range(0, 149) == 0);
            s.flush = ($urandom_range(0, 49) == 0);
            s.valid = ($urandom_range(0, 9) < 8);
            s.cls   = 4'($urandom_range(0, 5));
            s.rs1   = 5'($urandom_range(0, 7));
            s.rs2   = 5'($urandom_range(0, 7));
            s.wd    = 5'($urandom_range(0, 7));
            s.wr    = ($urandom_range(0, 9) < 7);
            s.wbv   = 0;
            s.wba   = '0;
            if ($urandom_range(0, 9) < 4) begin
                tries = 0;
                while (!s.wbv && tries < 4) begin
                    s.wba = 5'($urandom_range(1, 7));
                    if (m_cnt[s.wba] > 0) s.wbv = 1;
                    tries++;
                end
                if (!s.wbv && $urandom_range(0, 7) == 0) s.wbv = 1;
            end
            apply(s);
        end

        for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
        @(negedge clk);
        #4;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d responses left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
